fft_frame_ctrl: RTL and testbench

- Sequences the 64-point streaming R2²SDF FFT core (fft64) in whole-frame bursts.
- Buffers upstream valid/ready samples and issues contiguous 64-cycle di_en bursts only when a full frame is held.
- Limits the number of frames in flight through the pipeline and tracks output frames.
- Tags downstream samples with first/last markers and raises sticky errors on protocol faults from the core.

---
 rtl/fft_frame_ctrl.sv | 248 ++++++++++++++++++++++++
 tb/tb_fft_frame_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl: frame sequencer for the 64-point streaming FFT core.
//
// Upstream samples are collected in a circular buffer. A contiguous N-cycle
// di_en burst is issued only when a whole frame is held and the core has room
// for another frame in flight. Core outputs are retimed, tagged with first/last
// markers, and checked for protocol faults, which raise sticky error flags.
//
// Ports:
//   clock, reset            clock and synchronous active-low reset
//   s_valid/s_ready/s_re/s_im  upstream sample stream (valid/ready)
//   fft_reset               active-high core reset (registered ~reset)
//   di_en/di_re/di_im       registered core input
//   do_en/do_re/do_im       core output
//   m_valid/m_re/m_im/m_first/m_last  downstream stream (no backpressure)
//   inflight                frames issued whose output is not yet complete
//   err_gap/err_spur/err_timeout  sticky protocol error flags
module fft_frame_ctrl #(
  parameter int unsigned N            = 64,
  parameter int unsigned WIDTH        = 16,
  parameter int unsigned DEPTH        = 128,
  parameter int unsigned MAX_INFLIGHT = 2,
  parameter int unsigned TIMEOUT      = 512
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            s_valid,
  output logic                            s_ready,
  input  logic [WIDTH-1:0]                s_re,
  input  logic [WIDTH-1:0]                s_im,
  output logic                            fft_reset,
  output logic                            di_en,
  output logic [WIDTH-1:0]                di_re,
  output logic [WIDTH-1:0]                di_im,
  input  logic                            do_en,
  input  logic [WIDTH-1:0]                do_re,
  input  logic [WIDTH-1:0]                do_im,
  output logic                            m_valid,
  output logic [WIDTH-1:0]                m_re,
  output logic [WIDTH-1:0]                m_im,
  output logic                            m_first,
  output logic                            m_last,
  output logic [$clog2(MAX_INFLIGHT):0]   inflight,
  output logic                            err_gap,
  output logic                            err_spur,
  output logic                            err_timeout
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned IdxW = $clog2(N);
  localparam int unsigned IflW = $clog2(MAX_INFLIGHT) + 1;
  localparam int unsigned TmrW = $clog2(TIMEOUT + 1);

  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  // Sample buffer (not reset: pointers and count define what is valid).
  logic [WIDTH-1:0] r_mem_re [DEPTH];
  logic [WIDTH-1:0] r_mem_im [DEPTH];

  logic [PtrW-1:0] r_wr_ptr;
  logic [PtrW-1:0] r_rd_ptr;
  logic [CntW-1:0] r_count;
  logic [CntW-1:0] w_count_d;
  state_e          r_state;
  logic [IdxW-1:0] r_rd_cnt;
  logic [IflW-1:0] r_inflight;
  logic [IflW-1:0] w_inflight_d;
  logic [IdxW-1:0] r_out_idx;
  logic [TmrW-1:0] r_timer;

  logic             r_fft_reset;
  logic             r_di_en;
  logic [WIDTH-1:0] r_di_re;
  logic [WIDTH-1:0] r_di_im;
  logic             r_m_valid;
  logic [WIDTH-1:0] r_m_re;
  logic [WIDTH-1:0] r_m_im;
  logic             r_m_first;
  logic             r_m_last;
  logic             r_err_gap;
  logic             r_err_spur;
  logic             r_err_timeout;

  logic w_wr;
  logic w_rd;
  logic w_room;
  logic w_inc;
  logic w_dec;

  assign s_ready = (r_count < CntW'(DEPTH));
  assign w_wr    = s_valid && s_ready;
  assign w_rd    = (r_state == StBurst);
  assign w_room  = (r_inflight < IflW'(MAX_INFLIGHT));
  // A frame's output completes on its last bin; spurious frames never underflow.
  assign w_dec   = do_en && (r_out_idx == IdxW'(N - 1)) && (r_inflight != '0);

  // A new frame starts either from idle or back-to-back at the end of a burst.
  // At the burst end the read of this cycle is already accounted for (count-1).
  always_comb begin
    w_inc = 1'b0;
    if (r_state == StIdle) begin
      w_inc = (r_count >= CntW'(N)) && w_room;
    end else if (r_rd_cnt == IdxW'(N - 1)) begin
      w_inc = ((r_count - CntW'(1)) >= CntW'(N)) && w_room;
    end
  end

  always_comb begin
    w_count_d = r_count;
    unique case ({w_wr, w_rd})
      2'b10:   w_count_d = r_count + CntW'(1);
      2'b01:   w_count_d = r_count - CntW'(1);
      default: w_count_d = r_count;
    endcase
  end

  always_comb begin
    w_inflight_d = r_inflight;
    unique case ({w_inc, w_dec})
      2'b10:   w_inflight_d = r_inflight + IflW'(1);
      2'b01:   w_inflight_d = r_inflight - IflW'(1);
      default: w_inflight_d = r_inflight;
    endcase
  end

  always_ff @(posedge clock) begin
    r_fft_reset <= ~reset;
  end

  always_ff @(posedge clock) begin
    if (w_wr) begin
      r_mem_re[r_wr_ptr] <= s_re;
      r_mem_im[r_wr_ptr] <= s_im;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_inflight <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + PtrW'(1);
      end
      r_count    <= w_count_d;
      r_inflight <= w_inflight_d;
    end
  end

  // Input FSM: drives the core one sample per cycle while in StBurst.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state  <= StIdle;
      r_rd_cnt <= '0;
      r_rd_ptr <= '0;
      r_di_en  <= 1'b0;
      r_di_re  <= '0;
      r_di_im  <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          r_di_en <= 1'b0;
          if (w_inc) begin
            r_state  <= StBurst;
            r_rd_cnt <= '0;
          end
        end
        StBurst: begin
          r_di_en  <= 1'b1;
          r_di_re  <= r_mem_re[r_rd_ptr];
          r_di_im  <= r_mem_im[r_rd_ptr];
          r_rd_ptr <= r_rd_ptr + PtrW'(1);
          if (r_rd_cnt == IdxW'(N - 1)) begin
            r_rd_cnt <= '0;
            if (!w_inc) begin
              r_state <= StIdle;
            end
          end else begin
            r_rd_cnt <= r_rd_cnt + IdxW'(1);
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Output retiming, bin tracking and protocol checks.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_m_valid     <= 1'b0;
      r_m_re        <= '0;
      r_m_im        <= '0;
      r_m_first     <= 1'b0;
      r_m_last      <= 1'b0;
      r_out_idx     <= '0;
      r_timer       <= '0;
      r_err_gap     <= 1'b0;
      r_err_spur    <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      r_m_valid <= do_en;
      r_m_re    <= do_re;
      r_m_im    <= do_im;
      r_m_first <= do_en && (r_out_idx == '0);
      r_m_last  <= do_en && (r_out_idx == IdxW'(N - 1));

      // A drop in do_en always realigns to bin 0; mid-frame it is a fault.
      if (do_en) begin
        r_out_idx <= r_out_idx + IdxW'(1);
      end else begin
        r_out_idx <= '0;
        if (r_out_idx != '0) begin
          r_err_gap <= 1'b1;
        end
      end

      if (do_en && (r_inflight == '0) && (r_out_idx == '0)) begin
        r_err_spur <= 1'b1;
      end

      // Timer saturates at TIMEOUT; the flag sets on the edge it gets there.
      if (do_en || (r_inflight == '0)) begin
        r_timer <= '0;
      end else if (r_timer != TmrW'(TIMEOUT)) begin
        r_timer <= r_timer + TmrW'(1);
        if (r_timer == TmrW'(TIMEOUT - 1)) begin
          r_err_timeout <= 1'b1;
        end
      end
    end
  end

  assign fft_reset   = r_fft_reset;
  assign di_en       = r_di_en;
  assign di_re       = r_di_re;
  assign di_im       = r_di_im;
  assign m_valid     = r_m_valid;
  assign m_re        = r_m_re;
  assign m_im        = r_m_im;
  assign m_first     = r_m_first;
  assign m_last      = r_m_last;
  assign inflight    = r_inflight;
  assign err_gap     = r_err_gap;
  assign err_spur    = r_err_spur;
  assign err_timeout = r_err_timeout;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Testbench for fft_frame_ctrl: directed sessions with a core model driven
// from the main sequence and scoreboards for core input and downstream output.
module tb_fft_frame_ctrl;

  localparam int N = 64;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [15:0] s_re = '0;
  logic [15:0] s_im = '0;
  logic        fft_reset;
  logic        di_en;
  logic [15:0] di_re;
  logic [15:0] di_im;
  logic        do_en = 1'b0;
  logic [15:0] do_re = '0;
  logic [15:0] do_im = '0;
  logic        m_valid;
  logic [15:0] m_re;
  logic [15:0] m_im;
  logic        m_first;
  logic        m_last;
  logic [1:0]  inflight;
  logic        err_gap;
  logic        err_spur;
  logic        err_timeout;

  fft_frame_ctrl #(
    .N            (64),
    .WIDTH        (16),
    .DEPTH        (128),
    .MAX_INFLIGHT (2),
    .TIMEOUT      (512)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_re        (s_re),
    .s_im        (s_im),
    .fft_reset   (fft_reset),
    .di_en       (di_en),
    .di_re       (di_re),
    .di_im       (di_im),
    .do_en       (do_en),
    .do_re       (do_re),
    .do_im       (do_im),
    .m_valid     (m_valid),
    .m_re        (m_re),
    .m_im        (m_im),
    .m_first     (m_first),
    .m_last      (m_last),
    .inflight    (inflight),
    .err_gap     (err_gap),
    .err_spur    (err_spur),
    .err_timeout (err_timeout)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] q_di[$];
  logic [33:0] q_m[$];
  logic [63:0] di_exp;
  logic [63:0] m_exp;

  int di_run       = 0;
  int di_last_run  = 0;
  int di_total     = 0;
  int di_start_cyc = 0;
  int last_acc_cyc = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Core input monitor: every di_en cycle pops the next buffered sample.
  always begin
    @(posedge clock);
    #1;
    if (di_en === 1'b1) begin
      if (q_di.size() != 0) di_exp = {32'b0, q_di.pop_front()};
      else di_exp = 64'bx;
      chk("di_data", {32'b0, di_re, di_im}, di_exp);
      if (di_run == 0) di_start_cyc = cyc;
      di_run++;
      di_total++;
    end else if (di_run != 0) begin
      di_last_run = di_run;
      di_run = 0;
    end
  end

  // Downstream monitor: every m_valid cycle pops the expected tagged sample.
  always begin
    @(posedge clock);
    #1;
    if (m_valid === 1'b1) begin
      if (q_m.size() != 0) m_exp = {30'b0, q_m.pop_front()};
      else m_exp = 64'bx;
      chk("m_data_tags", {30'b0, m_re, m_im, m_first, m_last}, m_exp);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic push(input logic [15:0] re, input logic [15:0] im);
    int g = 0;
    s_valid = 1'b1;
    s_re = re;
    s_im = im;
    while (s_ready !== 1'b1 && g < 2000) begin
      step();
      g++;
    end
    if (s_ready !== 1'b1) chk("push_ready", {63'b0, s_ready}, 64'd1);
    q_di.push_back({re, im});
    step();
    last_acc_cyc = cyc;
    s_valid = 1'b0;
  endtask

  task automatic wait_total(input string tag, input int exp_total);
    int g = 0;
    while (!(di_total >= exp_total && di_en !== 1'b1) && g < 2000) begin
      step();
      g++;
    end
    chk(tag, 64'(di_total), 64'(exp_total));
  endtask

  // Core model: emits bins with a recognisable pattern and records expected tags.
  task automatic emit(input int first_bin, input int nbins, input int base);
    for (int k = first_bin; k < first_bin + nbins; k++) begin
      do_en = 1'b1;
      do_re = 16'(base + k);
      do_im = ~16'(base + k);
      q_m.push_back({16'(base + k), ~16'(base + k), (k == 0), (k == N - 1)});
      step();
    end
    do_en = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    s_valid = 1'b0;
    do_en = 1'b0;
    q_di.delete();
    q_m.delete();
    step();
    step();
    di_total = 0;
    chk("rst_di_en", {63'b0, di_en}, 64'd0);
    chk("rst_di_re", {48'b0, di_re}, 64'd0);
    chk("rst_m_valid", {63'b0, m_valid}, 64'd0);
    chk("rst_m_first_last", {62'b0, m_first, m_last}, 64'd0);
    chk("rst_inflight", {62'b0, inflight}, 64'd0);
    chk("rst_errs", {61'b0, err_gap, err_spur, err_timeout}, 64'd0);
    chk("rst_fft_reset", {63'b0, fft_reset}, 64'd1);
    chk("rst_s_ready", {63'b0, s_ready}, 64'd1);
    reset = 1'b1;
    step();
    chk("rel_fft_reset", {63'b0, fft_reset}, 64'd0);
  endtask

  initial begin
    int t;
    int g;

    // Session 1: single frame, latency, timeout, tagged output, spurious output.
    do_reset();
    for (int k = 0; k < 64; k++) push(16'(k), 16'(-k));
    t = last_acc_cyc;
    wait_total("s1_total", 64);
    chk("s1_burst_start", 64'(di_start_cyc), 64'(t + 2));
    chk("s1_run_len", 64'(di_last_run), 64'd64);
    chk("s1_inflight", {62'b0, inflight}, 64'd1);
    g = 0;
    while (cyc < t + 512 && g < 1000) begin
      step();
      g++;
    end
    chk("s1_timeout_before", {63'b0, err_timeout}, 64'd0);
    step();
    chk("s1_timeout_at", {63'b0, err_timeout}, 64'd1);
    emit(0, 64, 1000);
    chk("s1_inflight_done", {62'b0, inflight}, 64'd0);
    chk("s1_no_gap_spur", {62'b0, err_gap, err_spur}, 64'd0);
    emit(0, 1, 700);
    chk("s1_spur", {63'b0, err_spur}, 64'd1);
    step();

    // Session 2: do_en dropped mid-frame, then realigned frame.
    do_reset();
    for (int k = 0; k < 64; k++) push(16'(16'h0100 + k), 16'(k));
    wait_total("s2_total", 64);
    emit(0, 30, 500);
    step();
    chk("s2_gap_set", {63'b0, err_gap}, 64'd1);
    emit(0, 64, 600);
    chk("s2_gap_sticky", {63'b0, err_gap}, 64'd1);
    chk("s2_inflight", {62'b0, inflight}, 64'd0);
    chk("s2_spur_timeout", {62'b0, err_spur, err_timeout}, 64'd0);

    // Session 3: 128 contiguous samples give two back-to-back frames.
    do_reset();
    for (int k = 0; k < 128; k++) push(16'(16'h2000 + k), 16'(16'h3000 - k));
    wait_total("s3_total", 128);
    chk("s3_run_len", 64'(di_last_run), 64'd128);
    chk("s3_inflight", {62'b0, inflight}, 64'd2);

    // Session 4: silent core fills the buffer; one output frame frees a slot.
    do_reset();
    for (int k = 0; k < 256; k++) push(16'(16'h5000 + k), 16'(k * 3));
    chk("s4_s_ready_full", {63'b0, s_ready}, 64'd0);
    wait_total("s4_total", 128);
    chk("s4_run_len", 64'(di_last_run), 64'd128);
    chk("s4_inflight", {62'b0, inflight}, 64'd2);
    for (int k = 0; k < 20; k++) step();
    chk("s4_no_third", 64'(di_total), 64'd128);
    emit(0, 64, 300);
    chk("s4_inflight_dec", {62'b0, inflight}, 64'd1);
    wait_total("s4_total3", 192);
    chk("s4_run3_len", 64'(di_last_run), 64'd64);
    for (int k = 256; k < 300; k++) push(16'(16'h5000 + k), 16'(k * 3));
    step();
    chk("s4_s_ready_tail", {63'b0, s_ready}, 64'd1);
    chk("s4_inflight_tail", {62'b0, inflight}, 64'd2);
    chk("s4_total_tail", 64'(di_total), 64'd192);

    // Session 5: reset asserted at burst sample 20, then a fresh frame.
    do_reset();
    for (int k = 0; k < 64; k++) push(16'(16'h7000 + k), 16'(k));
    g = 0;
    while (di_run < 20 && g < 200) begin
      step();
      g++;
    end
    chk("s5_reached_20", 64'(di_run), 64'd20);
    reset = 1'b0;
    q_di.delete();
    di_total = 0;
    step();
    chk("s5_di_en_off", {63'b0, di_en}, 64'd0);
    chk("s5_fft_reset", {63'b0, fft_reset}, 64'd1);
    chk("s5_s_ready", {63'b0, s_ready}, 64'd1);
    chk("s5_inflight", {62'b0, inflight}, 64'd0);
    step();
    reset = 1'b1;
    step();
    for (int k = 0; k < 64; k++) push(16'(16'h4000 + k), 16'(16'h0800 + k));
    t = last_acc_cyc;
    wait_total("s5_total", 64);
    chk("s5_burst_start", 64'(di_start_cyc), 64'(t + 2));
    chk("s5_run_len", 64'(di_last_run), 64'd64);

    step();
    chk("q_di_drained", 64'(q_di.size()), 64'd0);
    chk("q_m_drained", 64'(q_m.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
